// File: rtl/regfile_mp_sb_if.sv
// Register-file bus: read ports, two write ports and the reservation request.
// The decode/writeback side drives it through the master modport.
interface regfile_mp_sb_if #(
   parameter int DATA_W = 32,
   parameter int ADDR_W = 5,
   parameter int NUM_RD = 2
);
   logic [NUM_RD*ADDR_W-1:0] rd_addr;
   logic [NUM_RD*DATA_W-1:0] rd_data;
   logic [NUM_RD-1:0]        rd_busy;
   logic                     we0;
   logic [ADDR_W-1:0]        wa0;
   logic [DATA_W-1:0]        wd0;
   logic                     we1;
   logic [ADDR_W-1:0]        wa1;
   logic [DATA_W-1:0]        wd1;
   logic                     rsv_en;
   logic [ADDR_W-1:0]        rsv_addr;
   logic [ADDR_W:0]          busy_cnt;

   modport master (
      output rd_addr, we0, wa0, wd0, we1, wa1, wd1, rsv_en, rsv_addr,
      input  rd_data, rd_busy, busy_cnt
   );

   modport slave (
      input  rd_addr, we0, wa0, wd0, we1, wa1, wd1, rsv_en, rsv_addr,
      output rd_data, rd_busy, busy_cnt
   );
endinterface

// File: rtl/regfile_mp_sb.sv
// Multi-port register file: NUM_RD registered read ports with write bypass,
// two write ports (W1 wins on collision) and a per-register busy scoreboard.
module regfile_mp_sb #(
   parameter int DATA_W   = 32,
   parameter int ADDR_W   = 5,
   parameter int NUM_RD   = 2,
   parameter int ZERO_REG = 1
) (
   input logic             clk,
   input logic             rst,
   regfile_mp_sb_if.slave  bus
);
   localparam int DEPTH = 1 << ADDR_W;
   localparam int CW    = ADDR_W + 1;

   logic [DATA_W-1:0] mem_q [DEPTH];
   logic [DEPTH-1:0]  busy_q;
   logic [DEPTH-1:0]  busy_d;
   logic [CW-1:0]     busy_cnt_q;
   logic [CW-1:0]     busy_cnt_d;
   logic [DATA_W-1:0] rd_data_q [NUM_RD];
   logic [DATA_W-1:0] rd_data_d [NUM_RD];
   logic [NUM_RD-1:0] rd_busy_q;
   logic [NUM_RD-1:0] rd_busy_d;

   logic we0_eff, we1_eff, rsv_eff;
   logic set_new, clr0, clr1;

   // Writes and reservations aimed at a hardwired zero register are dropped.
   always_comb begin
      we0_eff = bus.we0    && !((ZERO_REG != 0) && (bus.wa0 == '0));
      we1_eff = bus.we1    && !((ZERO_REG != 0) && (bus.wa1 == '0));
      rsv_eff = bus.rsv_en && !((ZERO_REG != 0) && (bus.rsv_addr == '0));
   end

   genvar gi;
   generate
      for (gi = 0; gi < DEPTH; gi++) begin : g_busy
         assign busy_d[gi] =
            (rsv_eff && (bus.rsv_addr == ADDR_W'(gi))) ? 1'b1 :
            ((we0_eff && (bus.wa0 == ADDR_W'(gi))) ||
             (we1_eff && (bus.wa1 == ADDR_W'(gi)))) ? 1'b0 :
            busy_q[gi];
      end
   endgenerate

   // Incremental popcount: a clear is ignored when the same register is being
   // re-reserved, and W1 does not double-count a register W0 already clears.
   always_comb begin
      set_new = rsv_eff && !busy_q[bus.rsv_addr];
      clr0    = we0_eff && busy_q[bus.wa0] &&
                !(rsv_eff && (bus.rsv_addr == bus.wa0));
      clr1    = we1_eff && busy_q[bus.wa1] &&
                !(rsv_eff && (bus.rsv_addr == bus.wa1)) &&
                !(we0_eff && (bus.wa0 == bus.wa1));
      busy_cnt_d = busy_cnt_q + CW'(set_new) - CW'(clr0) - CW'(clr1);
   end

   generate
      for (gi = 0; gi < NUM_RD; gi++) begin : g_rd
         logic [ADDR_W-1:0] addr;
         assign addr = bus.rd_addr[gi*ADDR_W +: ADDR_W];

         always_comb begin
            rd_data_d[gi] = mem_q[addr];
            if ((ZERO_REG != 0) && (addr == '0)) begin
               rd_data_d[gi] = '0;
            end else if (bus.we1 && (bus.wa1 == addr)) begin
               rd_data_d[gi] = bus.wd1;
            end else if (bus.we0 && (bus.wa0 == addr)) begin
               rd_data_d[gi] = bus.wd0;
            end
         end

         assign rd_busy_d[gi] = busy_d[addr];
         assign bus.rd_data[gi*DATA_W +: DATA_W] = rd_data_q[gi];
      end
   endgenerate

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         for (int i = 0; i < DEPTH; i++) begin
            mem_q[i] <= '0;
         end
         for (int p = 0; p < NUM_RD; p++) begin
            rd_data_q[p] <= '0;
         end
         busy_q     <= '0;
         busy_cnt_q <= '0;
         rd_busy_q  <= '0;
      end else begin
         // W1 is assigned last so it wins an address collision.
         if (we0_eff) mem_q[bus.wa0] <= bus.wd0;
         if (we1_eff) mem_q[bus.wa1] <= bus.wd1;
         for (int p = 0; p < NUM_RD; p++) begin
            rd_data_q[p] <= rd_data_d[p];
         end
         busy_q     <= busy_d;
         busy_cnt_q <= busy_cnt_d;
         rd_busy_q  <= rd_busy_d;
      end
   end

   assign bus.rd_busy  = rd_busy_q;
   assign bus.busy_cnt = busy_cnt_q;
endmodule

// File: tb/tb_regfile_mp_sb.sv
// Directed bench for regfile_mp_sb: bypass, write collision, zero register,
// scoreboard counting and asynchronous reset.
module tb_regfile_mp_sb;
   logic clk;
   logic rst;
   int   total;
   int   bad;

   regfile_mp_sb_if #(.DATA_W(32), .ADDR_W(5), .NUM_RD(2)) bus ();

   regfile_mp_sb #(.DATA_W(32), .ADDR_W(5), .NUM_RD(2), .ZERO_REG(1)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
      $display("check %-12s observed=%h expected=%h", tag, obs, exp);
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic idle();
      bus.we0 = 1'b0; bus.we1 = 1'b0; bus.rsv_en = 1'b0;
   endtask

   task automatic rd(input logic [4:0] a0, input logic [4:0] a1);
      bus.rd_addr = {a1, a0};
   endtask

   initial begin
      total = 0;
      bad   = 0;
      rst   = 1'b0;
      bus.rd_addr = '0;
      bus.we0 = 1'b0; bus.wa0 = '0; bus.wd0 = '0;
      bus.we1 = 1'b0; bus.wa1 = '0; bus.wd1 = '0;
      bus.rsv_en = 1'b0; bus.rsv_addr = '0;
      repeat (3) tick();
      chk("rst_cnt", 32'(bus.busy_cnt), 32'd0);
      #2 rst = 1'b1;

      // Reset state on regs 0 and 31
      rd(5'd0, 5'd31);
      tick();
      chk("rst_rd0", bus.rd_data[31:0], 32'h0);
      chk("rst_rd1", bus.rd_data[63:32], 32'h0);
      chk("rst_busy", 32'(bus.rd_busy), 32'h0);
      chk("rst_cnt2", 32'(bus.busy_cnt), 32'd0);

      // Bypass then storage
      rd(5'd5, 5'd31);
      bus.we0 = 1'b1; bus.wa0 = 5'd5; bus.wd0 = 32'hDEADBEEF;
      tick();
      chk("byp_w0", bus.rd_data[31:0], 32'hDEADBEEF);
      idle();
      tick();
      chk("store_r5", bus.rd_data[31:0], 32'hDEADBEEF);

      // Collision on reg 7: W1 wins
      rd(5'd7, 5'd7);
      bus.we0 = 1'b1; bus.wa0 = 5'd7; bus.wd0 = 32'h11;
      bus.we1 = 1'b1; bus.wa1 = 5'd7; bus.wd1 = 32'h22;
      tick();
      chk("coll_rd0", bus.rd_data[31:0], 32'h22);
      chk("coll_rd1", bus.rd_data[63:32], 32'h22);
      idle();
      tick();
      chk("coll_st0", bus.rd_data[31:0], 32'h22);
      chk("coll_st1", bus.rd_data[63:32], 32'h22);

      // Zero register ignores writes, even on the bypass path
      rd(5'd0, 5'd0);
      bus.we0 = 1'b1; bus.wa0 = 5'd0; bus.wd0 = 32'h55;
      tick();
      chk("zero_byp", bus.rd_data[31:0], 32'h0);
      idle();
      tick();
      chk("zero_st", bus.rd_data[63:32], 32'h0);

      // Reserve reg 3, then clear it with W1
      rd(5'd3, 5'd7);
      bus.rsv_en = 1'b1; bus.rsv_addr = 5'd3;
      tick();
      chk("rsv3_busy", 32'(bus.rd_busy), 32'b01);
      chk("rsv3_cnt", 32'(bus.busy_cnt), 32'd1);
      idle();
      bus.we1 = 1'b1; bus.wa1 = 5'd3; bus.wd1 = 32'h99;
      tick();
      chk("clr3_busy", 32'(bus.rd_busy), 32'b00);
      chk("clr3_data", bus.rd_data[31:0], 32'h99);
      chk("clr3_cnt", 32'(bus.busy_cnt), 32'd0);

      // Reg 4: reserve, then reserve+write together keeps it busy
      idle();
      rd(5'd4, 5'd4);
      bus.rsv_en = 1'b1; bus.rsv_addr = 5'd4;
      tick();
      chk("rsv4_cnt", 32'(bus.busy_cnt), 32'd1);
      bus.we0 = 1'b1; bus.wa0 = 5'd4; bus.wd0 = 32'hAA;
      tick();
      chk("rw4_busy", 32'(bus.rd_busy), 32'b11);
      chk("rw4_cnt", 32'(bus.busy_cnt), 32'd1);
      chk("rw4_data", bus.rd_data[31:0], 32'hAA);
      idle();
      bus.rsv_en = 1'b1; bus.rsv_addr = 5'd4;
      tick();
      chk("rerv4_cnt", 32'(bus.busy_cnt), 32'd1);
      idle();
      bus.we1 = 1'b1; bus.wa1 = 5'd4; bus.wd1 = 32'hAB;
      tick();
      chk("clr4_cnt", 32'(bus.busy_cnt), 32'd0);
      chk("clr4_data", bus.rd_data[63:32], 32'hAB);

      // Regs 8 and 9 cleared together: 2 -> 0
      idle();
      rd(5'd8, 5'd9);
      bus.rsv_en = 1'b1; bus.rsv_addr = 5'd8;
      tick();
      bus.rsv_addr = 5'd9;
      tick();
      chk("rsv89_cnt", 32'(bus.busy_cnt), 32'd2);
      chk("rsv89_busy", 32'(bus.rd_busy), 32'b11);
      idle();
      bus.we0 = 1'b1; bus.wa0 = 5'd8; bus.wd0 = 32'h1;
      bus.we1 = 1'b1; bus.wa1 = 5'd9; bus.wd1 = 32'h2;
      tick();
      chk("clr89_cnt", 32'(bus.busy_cnt), 32'd0);
      chk("clr89_busy", 32'(bus.rd_busy), 32'b00);

      // Both write ports clearing the same register count once
      idle();
      rd(5'd10, 5'd10);
      bus.rsv_en = 1'b1; bus.rsv_addr = 5'd10;
      tick();
      idle();
      bus.we0 = 1'b1; bus.wa0 = 5'd10; bus.wd0 = 32'h3;
      bus.we1 = 1'b1; bus.wa1 = 5'd10; bus.wd1 = 32'h4;
      tick();
      chk("dbl_cnt", 32'(bus.busy_cnt), 32'd0);
      chk("dbl_data", bus.rd_data[31:0], 32'h4);

      // Reserving reg 0 has no effect
      idle();
      rd(5'd0, 5'd10);
      bus.rsv_en = 1'b1; bus.rsv_addr = 5'd0;
      tick();
      chk("rsv0_cnt", 32'(bus.busy_cnt), 32'd0);
      chk("rsv0_busy", 32'(bus.rd_busy), 32'b00);

      // Three busy, then asynchronous reset mid-cycle
      idle();
      rd(5'd5, 5'd7);
      bus.rsv_en = 1'b1; bus.rsv_addr = 5'd11;
      tick();
      bus.rsv_addr = 5'd12;
      tick();
      bus.rsv_addr = 5'd13;
      tick();
      idle();
      chk("pre_cnt", 32'(bus.busy_cnt), 32'd3);
      chk("pre_rd0", bus.rd_data[31:0], 32'hDEADBEEF);
      bus.we0 = 1'b1; bus.wa0 = 5'd5; bus.wd0 = 32'h77;
      #2 rst = 1'b0;
      #1;
      chk("arst_cnt", 32'(bus.busy_cnt), 32'd0);
      chk("arst_rd0", bus.rd_data[31:0], 32'h0);
      chk("arst_rd1", bus.rd_data[63:32], 32'h0);
      tick();
      idle();
      #2 rst = 1'b1;
      tick();
      chk("post_rd0", bus.rd_data[31:0], 32'h0);
      chk("post_rd1", bus.rd_data[63:32], 32'h0);
      rd(5'd12, 5'd4);
      tick();
      chk("post_busy", 32'(bus.rd_busy), 32'b00);
      chk("post_r4", bus.rd_data[63:32], 32'h0);
      chk("post_cnt", 32'(bus.busy_cnt), 32'd0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule

// File: doc/regfile_mp_sb.md
Name: regfile_mp_sb

Overview:
- Parametrised multi-port register file for the MIPS datapath, succeeding the fixed 2-read/1-write file.
- Provides NUM_RD registered read ports and two write ports, with same-cycle write-to-read bypass and an optional hardwired zero register.
- A per-register busy scoreboard lets the decode stage detect pending multi-cycle producers and stall.
- Sits between decode (reads, reserves) and writeback (ALU result on W0, memory/multi-cycle result on W1).

Parameters:
- DATA_W, 32, register width in bits
- ADDR_W, 5, register address width; depth = 2**ADDR_W
- NUM_RD, 2, number of read ports (1..4)
- ZERO_REG, 1, 1 = register 0 reads as zero, ignores writes, and can never be busy

Ports:
- clk  in  1  clock, rising edge
- rst  in  1  asynchronous active-low reset
- rd_addr  in  NUM_RD*ADDR_W  read addresses, port p at bits [p*ADDR_W +: ADDR_W]
- rd_data  out  NUM_RD*DATA_W  registered read data, port p at [p*DATA_W +: DATA_W]
- rd_busy  out  NUM_RD  registered busy flag per read port
- we0  in  1  write enable, port 0
- wa0  in  ADDR_W  write address, port 0
- wd0  in  DATA_W  write data, port 0
- we1  in  1  write enable, port 1
- wa1  in  ADDR_W  write address, port 1
- wd1  in  DATA_W  write data, port 1
- rsv_en  in  1  mark register rsv_addr busy (pending producer)
- rsv_addr  in  ADDR_W  register to reserve
- busy_cnt  out  ADDR_W+1  number of registers currently busy

Behaviour:
- Reset: rst low clears, asynchronously, all storage, all busy bits, rd_data, rd_busy and busy_cnt to 0.
- Read latency: 1 cycle. rd_data[p] and rd_busy[p] sampled at edge N reflect rd_addr[p] presented before edge N.
- Read value at each edge, per port, first match wins:
  - 0 if ZERO_REG and addr == 0;
  - wd1 if we1 and wa1 == addr;
  - wd0 if we0 and wa0 == addr;
  - otherwise stored value.
- Every read port is independent; all ports may address the same register.
- Writes: mem[wa0] <= wd0 if we0; mem[wa1] <= wd1 if we1.
  - Same address on both ports: port 1 wins in storage and in bypass.
  - Writes to register 0 are discarded when ZERO_REG = 1.
- Scoreboard, per register r, busy_next:
  - set if rsv_en and rsv_addr == r;
  - else cleared if (we0 and wa0 == r) or (we1 and wa1 == r);
  - else holds.
  - Reserve and write to the same register in one cycle: register stays busy. The new producer wins; the write data is still stored.
  - ZERO_REG = 1: reserving register 0 has no effect.
  - Reserving an already-busy register keeps it busy; busy_cnt does not change.
- rd_busy[p] <= busy_next[rd_addr[p]], i.e. it includes this cycle's sets and clears, consistent with the bypassed data.
- busy_cnt <= popcount(busy_next), maintained incrementally:
  - +1 on a set of a clear bit;
  - -1 for each clear of a set bit;
  - a clear on both write ports to the same register counts once;
  - net change per cycle is in the range -2..+1.
  - Range is 0..2**ADDR_W (ZERO_REG = 1: max 2**ADDR_W - 1).
- Reset asserted mid-operation discards in-flight writes and reservations; no partial updates survive.
- No X may reach rd_data for any in-range address after reset.

Test Plan:
- Reset, then read regs 0 and 31 on both ports -> rd_data = 0, rd_busy = 0, busy_cnt = 0.
- we0 = 1, wa0 = 5, wd0 = 0xDEADBEEF with rd_addr0 = 5 in the same cycle -> next cycle rd_data0 = 0xDEADBEEF (bypass). Reading reg 5 again one cycle later -> 0xDEADBEEF from storage.
- we0 (wa0 = 7, wd0 = 0x11) and we1 (wa1 = 7, wd1 = 0x22) in the same cycle, both ports reading 7 -> both return 0x22; later read -> 0x22. Write 0x55 to reg 0 -> reads 0.
- rsv_en for reg 3 -> busy_cnt = 1, read of 3 gives rd_busy = 1. Then we1 to reg 3 with 0x99 -> next cycle rd_busy = 0, rd_data = 0x99, busy_cnt = 0.
- Reg 4 busy, then rsv_en reg 4 and we0 reg 4 with 0xAA in one cycle -> reg 4 stays busy, busy_cnt unchanged, data 0xAA. Reserve regs 8 and 9, then clear both via we0/we1 in one cycle -> busy_cnt 2 -> 0.
- Assert rst mid-stream with 3 registers busy -> immediately busy_cnt = 0, rd_data = 0. After release, prior-written registers read 0.
